// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with write-to-read bypass and a per-register
// pending bit for RAW (rd_pend) and WAW (iss_block) hazard detection.

module regfile_rd_port #(
   parameter int WIDTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int DEPTH    = 2**ADDR_W
) (
   input  logic                        arst_n,
   input  logic [ADDR_W-1:0]           addr,
   input  logic [DEPTH-1:0][WIDTH-1:0] regs,
   input  logic [DEPTH-1:0]            pend,
   input  logic                        wr_en,
   input  logic [ADDR_W-1:0]           wr_addr,
   input  logic [WIDTH-1:0]            wr_data,
   output logic [WIDTH-1:0]            data,
   output logic                        pending
);
   logic is_zero;
   logic is_bypass;

   assign is_zero   = (ZERO_REG != 0) && (addr == '0);
   assign is_bypass = wr_en && (wr_addr == addr);

   // Zero register wins over bypass; bypassed data is never pending.
   always_comb begin
      data    = '0;
      pending = 1'b0;
      if (arst_n && !is_zero) begin
         if (is_bypass) begin
            data = wr_data;
         end else begin
            data    = regs[addr];
            pending = pend[addr];
         end
      end
   end
endmodule

module regfile_scoreboard #(
   parameter int WIDTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                    clk,
   input  logic                    arst_n,
   input  logic [NREAD*ADDR_W-1:0] rd_addr,
   output logic [NREAD*WIDTH-1:0]  rd_data,
   output logic [NREAD-1:0]        rd_pend,
   input  logic                    wr_en,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [WIDTH-1:0]        wr_data,
   input  logic                    iss_en,
   input  logic [ADDR_W-1:0]       iss_addr,
   output logic                    iss_block,
   input  logic                    flush
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0][WIDTH-1:0] regs;
   logic [DEPTH-1:0]            pend;
   logic                        zero_wr;
   logic                        zero_iss;
   logic                        blk;

   assign zero_wr  = (ZERO_REG != 0) && (wr_addr == '0);
   assign zero_iss = (ZERO_REG != 0) && (iss_addr == '0);

   // A retiring write to the same register clears the hazard this cycle.
   assign blk       = pend[iss_addr] && !(wr_en && (wr_addr == iss_addr)) && !zero_iss;
   assign iss_block = arst_n && blk;

   genvar k;
   generate
      for (k = 0; k < NREAD; k++) begin : g_rd
         regfile_rd_port #(
            .WIDTH    (WIDTH),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .DEPTH    (DEPTH)
         ) u_rd (
            .arst_n  (arst_n),
            .addr    (rd_addr[k*ADDR_W +: ADDR_W]),
            .regs    (regs),
            .pend    (pend),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .data    (rd_data[k*WIDTH +: WIDTH]),
            .pending (rd_pend[k])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         regs <= '0;
      end else if (wr_en && !zero_wr) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Set after clear so a new producer owns the register over a same-cycle retire.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         pend <= '0;
      end else if (flush) begin
         pend <= '0;
      end else begin
         if (wr_en)
            pend[wr_addr] <= 1'b0;
         if (iss_en && !blk && !zero_iss)
            pend[iss_addr] <= 1'b1;
      end
   end
endmodule
